stream_mux_2x1: RTL

STREAM_MUX_2X1 -- requirements
Module: stream_mux_2x1

---
 rtl/stream_mux_2x1.sv | 105 ++++++++++
 1 files changed

// File: rtl/stream_mux_2x1.sv
// Two-source packet merge with per-packet round-robin arbitration.
// A packet that starts on one source holds the grant until its last beat,
// so packets never interleave. Each output beat carries its origin in y_src_out.
module stream_mux_2x1 #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic [WIDTH-1:0] a_data_in,
  input  logic             a_last_in,
  input  logic             a_valid_in,
  output logic             a_ready_out,
  input  logic [WIDTH-1:0] b_data_in,
  input  logic             b_last_in,
  input  logic             b_valid_in,
  output logic             b_ready_out,
  output logic [WIDTH-1:0] y_data_out,
  output logic             y_last_out,
  output logic             y_src_out,
  output logic             y_valid_out,
  input  logic             y_ready_in
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCK_A = 2'd1,
    LOCK_B = 2'd2
  } state_t;

  state_t state, state_nxt;
  logic   ptr, ptr_nxt;       // 0 = A has priority on a tie, 1 = B
  logic   grant_a, grant_b;
  logic   load_en;
  logic   acc_a, acc_b;
  logic   acc_last;

  // Grant selection: locked source only, otherwise single valid source or ptr on a tie
  always_comb begin
    grant_a = 1'b0;
    grant_b = 1'b0;
    unique case (state)
      LOCK_A: grant_a = 1'b1;
      LOCK_B: grant_b = 1'b1;
      default: begin
        if (a_valid_in && (!b_valid_in || !ptr)) grant_a = 1'b1;
        else if (b_valid_in)                     grant_b = 1'b1;
      end
    endcase
  end

  // Handshake: the single output slot can take a beat when empty or being drained
  always_comb begin
    load_en     = !y_valid_out || y_ready_in;
    a_ready_out = load_en && grant_a && !rst_in;
    b_ready_out = load_en && grant_b && !rst_in;
    acc_a       = a_valid_in && a_ready_out;
    acc_b       = b_valid_in && b_ready_out;
    acc_last    = acc_a ? a_last_in : b_last_in;
  end

  // Next state and pointer: lock on a non-final beat, release and hand priority
  // to the other source on a final beat
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    if (acc_a || acc_b) begin
      if (acc_last) begin
        state_nxt = IDLE;
        // ptr points away from the source that just finished a packet
        ptr_nxt   = acc_a;
      end else begin
        state_nxt = acc_a ? LOCK_A : LOCK_B;
      end
    end
  end

  // Arbitration state registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state <= IDLE;
      ptr   <= 1'b0;
    end else begin
      state <= state_nxt;
      ptr   <= ptr_nxt;
    end
  end

  // Output slot: load on an accepted beat, empty when drained with nothing new
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      y_valid_out <= 1'b0;
      y_data_out  <= '0;
      y_last_out  <= 1'b0;
      y_src_out   <= 1'b0;
    end else if (acc_a || acc_b) begin
      y_valid_out <= 1'b1;
      y_data_out  <= acc_a ? a_data_in : b_data_in;
      y_last_out  <= acc_last;
      y_src_out   <= acc_b;
    end else if (y_ready_in) begin
      y_valid_out <= 1'b0;
    end
  end

endmodule
